// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/stall sequencer.
// Forwarding selects, wait-FSM states and the forwarding priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mw_state_e;

  // M is the younger producer, so it wins over W; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wr_m,
    input logic       rw_m,
    input logic [4:0] wr_w,
    input logic       rw_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (rw_m && src == wr_m)
        sel = FWD_MEM;
      else if (rw_w && src == wr_w)
        sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait-state tracker with timeout.
// memwait is Mealy: it asserts in the same cycle the un-acked request appears.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic MemReqM,
  input  logic MemAckM,
  output logic memwait,
  output logic MemTimeout
);

  mw_state_e        state;
  mw_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    memwait = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemReqM && !MemAckM) begin
          state_n = WAIT;
          cnt_n   = CNT_W'(1);
          memwait = 1'b1;
        end
      end
      WAIT: begin
        if (MemAckM) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          memwait = 1'b1;
          if (cnt == CNT_W'(MEM_TIMEOUT))
            state_n = ERR;
          else
            cnt_n = cnt + CNT_W'(1);
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign MemTimeout = (state == ERR);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline.
// Forwarding selects, load/branch stalls, memory-wait freeze, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RsE,
  input  logic [4:0]        RtE,
  input  logic [4:0]        WriteRegE,
  input  logic [4:0]        WriteRegM,
  input  logic [4:0]        WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MemReqM,
  input  logic              MemAckM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MemTimeout,
  output logic [PERF_W-1:0] StallCount
);

  logic memwait;
  logic lwstall;
  logic brstall;
  logic hz;
  logic hz_only;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_mem_wait (
    .CLK       (CLK),
    .rst       (rst),
    .MemReqM   (MemReqM),
    .MemAckM   (MemAckM),
    .memwait   (memwait),
    .MemTimeout(MemTimeout)
  );

  assign ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM,
                             WriteRegW, RegWriteW);
  assign ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM,
                             WriteRegW, RegWriteW);

  assign ForwardAD = (RsD != 5'd0) && RegWriteM
                     && (RsD == WriteRegM);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM
                     && (RtD == WriteRegM);

  // $0 is deliberately not excluded here; a spurious stall is harmless.
  assign lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));

  assign brstall = BranchD && (
      (RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD)))
   || (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign hz      = lwstall | brstall;
  assign hz_only = hz & ~memwait;

  // A memory wait freezes the whole front end; E must keep its contents.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    unique case (1'b1)
      memwait: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end
      hz_only: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: begin
        StallF = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst)
      StallCount <= '0;
    else if (StallF && (StallCount != '1))
      StallCount <= StallCount + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int PW   = 3;
  localparam int CMAX = (1 << PW) - 1;

  logic          CLK;
  logic          rst;
  logic [4:0]    RsD, RtD, RsE, RtE;
  logic [4:0]    WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW;
  logic          MemtoRegE, MemtoRegM, BranchD;
  logic          MemReqM, MemAckM;
  logic          StallF, StallD, StallE, StallM, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ForwardAD, ForwardBD;
  logic          MemTimeout;
  logic [PW-1:0] StallCount;

  hazard_ctrl #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (3),
    .PERF_W     (PW)
  ) dut (
    .CLK(CLK), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic rwe, rwm, rww, m2re, m2rm, brd, req, ack, rst;
  } in_t;

  typedef struct {
    logic [1:0] fae, fbe;
    logic fad, fbd, sf, sd, se, sm, fe;
  } out_t;

  typedef struct {
    in_t        v;
    logic [1:0] fae, fbe;
    logic       fad, fbd, hz;
  } vec_t;

  int tests = 0;
  int fails = 0;

  bit m_err, m_wait;
  int m_age, m_cnt;
  vec_t tv[$];

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic in_t base();
    in_t v;
    v.rsd = 0; v.rtd = 0; v.rse = 0; v.rte = 0;
    v.wre = 0; v.wrm = 0; v.wrw = 0;
    v.rwe = 0; v.rwm = 0; v.rww = 0;
    v.m2re = 0; v.m2rm = 0; v.brd = 0;
    v.req = 0; v.ack = 0; v.rst = 1;
    return v;
  endfunction

  // Newest producer holding the register supplies it; $0 is never forwarded.
  function automatic logic [1:0] ref_fwd(logic [4:0] src, in_t v);
    logic [4:0] dst[2];
    logic       en[2];
    logic [1:0] code[2];
    dst[0] = v.wrm; en[0] = v.rwm; code[0] = 2'b10;
    dst[1] = v.wrw; en[1] = v.rww; code[1] = 2'b01;
    if (src == 0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (en[i] && dst[i] == src) return code[i];
    return 2'b00;
  endfunction

  function automatic bit ref_mw(in_t v);
    return !m_err && !v.ack && (m_wait || v.req);
  endfunction

  function automatic out_t ref_out(in_t v);
    out_t o;
    bit hz, mw;
    hz = (v.m2re && (v.rte == v.rsd || v.rte == v.rtd))
      || (v.brd && ((v.rwe && (v.wre == v.rsd || v.wre == v.rtd))
      || (v.m2rm && (v.wrm == v.rsd || v.wrm == v.rtd))));
    mw = ref_mw(v);
    o.fae = ref_fwd(v.rse, v);
    o.fbe = ref_fwd(v.rte, v);
    o.fad = (ref_fwd(v.rsd, v) == 2'b10);
    o.fbd = (ref_fwd(v.rtd, v) == 2'b10);
    o.sf = mw || hz; o.sd = mw || hz;
    o.se = mw; o.sm = mw;
    o.fe = hz && !mw;
    return o;
  endfunction

  task automatic set_in(in_t v);
    rst = v.rst;
    RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
    WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    MemtoRegE = v.m2re; MemtoRegM = v.m2rm; BranchD = v.brd;
    MemReqM = v.req; MemAckM = v.ack;
  endtask

  task automatic drive(in_t v);
    out_t o;
    set_in(v);
    #2;
    o = ref_out(v);
    chk("m.ForwardAE", ForwardAE, o.fae);
    chk("m.ForwardBE", ForwardBE, o.fbe);
    chk("m.ForwardAD", ForwardAD, o.fad);
    chk("m.ForwardBD", ForwardBD, o.fbd);
    chk("m.StallF", StallF, o.sf);
    chk("m.StallD", StallD, o.sd);
    chk("m.StallE", StallE, o.se);
    chk("m.StallM", StallM, o.sm);
    chk("m.FlushE", FlushE, o.fe);
    chk("m.MemTimeout", MemTimeout, m_err);
    chk("m.StallCount", StallCount, m_cnt);
  endtask

  // Wait model: count stalled cycles of the current access; erroring
  // once the access has stalled more than TO cycles.
  task automatic tick(in_t v);
    out_t o;
    bit   mw;
    o  = ref_out(v);
    mw = ref_mw(v);
    if (!v.rst) begin
      m_err = 0; m_wait = 0; m_age = 0; m_cnt = 0;
    end else begin
      if (o.sf && m_cnt < CMAX) m_cnt++;
      if (mw) begin
        m_wait = 1;
        m_age++;
        if (m_age > TO) begin
          m_err = 1; m_wait = 0;
        end
      end else if (m_wait && v.ack) begin
        m_wait = 0; m_age = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic add(in_t v, logic [1:0] fae, logic [1:0] fbe,
                     logic fad, logic fbd, logic hz);
    vec_t e;
    e.v = v; e.fae = fae; e.fbe = fbe;
    e.fad = fad; e.fbd = fbd; e.hz = hz;
    tv.push_back(e);
  endtask

  task automatic do_reset();
    in_t v;
    v = base();
    v.rst = 0;
    drive(v);
    tick(v);
  endtask

  initial begin
    in_t v;
    v = base();
    v.rst = 0;
    set_in(v);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    m_err = 0; m_wait = 0; m_age = 0; m_cnt = 0;
    chk("reset.MemTimeout", MemTimeout, 0);
    chk("reset.StallCount", StallCount, 0);

    // Load-use: one stall cycle, then bubble in E clears it.
    v = base(); v.m2re = 1; v.rte = 8; v.rsd = 8;
    drive(v);
    chk("lu.StallF", StallF, 1);
    chk("lu.StallD", StallD, 1);
    chk("lu.FlushE", FlushE, 1);
    chk("lu.StallE", StallE, 0);
    tick(v);
    v = base();
    drive(v);
    chk("lu.after.StallF", StallF, 0);
    chk("lu.after.FlushE", FlushE, 0);
    chk("lu.StallCount", StallCount, 1);
    tick(v);

    v = base(); v.rse = 5; v.wrm = 5; v.rwm = 1; v.wrw = 5; v.rww = 1;
    add(v, 2'b10, 2'b00, 0, 0, 0);
    v.rse = 0;
    add(v, 2'b00, 2'b00, 0, 0, 0);
    v = base(); v.rse = 6; v.wrw = 6; v.rww = 1; v.wrm = 7; v.rwm = 1;
    add(v, 2'b01, 2'b00, 0, 0, 0);
    v = base(); v.rte = 9; v.wrm = 9; v.wrw = 9; v.rww = 1;
    add(v, 2'b00, 2'b01, 0, 0, 0);
    v = base(); v.rte = 7; v.wrm = 7; v.rwm = 1; v.wrw = 7; v.rww = 1;
    add(v, 2'b00, 2'b10, 0, 0, 0);
    v = base(); v.rsd = 4; v.rtd = 4; v.wrm = 4; v.rwm = 1;
    add(v, 2'b00, 2'b00, 1, 1, 0);
    v = base(); v.rwm = 1;
    add(v, 2'b00, 2'b00, 0, 0, 0);
    v = base(); v.m2re = 1; v.rte = 8; v.rsd = 8; v.rtd = 1;
    add(v, 2'b00, 2'b00, 0, 0, 1);
    v = base(); v.m2re = 1; v.rsd = 1;
    add(v, 2'b00, 2'b00, 0, 0, 1);
    v = base(); v.m2re = 1; v.rte = 3; v.rsd = 1; v.rtd = 2;
    add(v, 2'b00, 2'b00, 0, 0, 0);
    v = base(); v.brd = 1; v.rwe = 1; v.wre = 3; v.rtd = 3; v.rsd = 1;
    add(v, 2'b00, 2'b00, 0, 0, 1);
    v = base(); v.brd = 1; v.m2rm = 1; v.rwm = 1; v.wrm = 1;
    v.rsd = 1; v.rtd = 2;
    add(v, 2'b00, 2'b00, 1, 0, 1);
    v = base(); v.brd = 1; v.rwm = 1; v.wrm = 3; v.rtd = 3; v.rsd = 1;
    add(v, 2'b00, 2'b00, 0, 1, 0);
    v = base(); v.rwe = 1; v.wre = 3; v.rtd = 3;
    add(v, 2'b00, 2'b00, 0, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].v);
      chk($sformatf("tv%0d.ForwardAE", i), ForwardAE, tv[i].fae);
      chk($sformatf("tv%0d.ForwardBE", i), ForwardBE, tv[i].fbe);
      chk($sformatf("tv%0d.ForwardAD", i), ForwardAD, tv[i].fad);
      chk($sformatf("tv%0d.ForwardBD", i), ForwardBD, tv[i].fbd);
      chk($sformatf("tv%0d.StallF", i), StallF, tv[i].hz);
      chk($sformatf("tv%0d.FlushE", i), FlushE, tv[i].hz);
      chk($sformatf("tv%0d.StallE", i), StallE, 0);
      tick(tv[i].v);
    end

    // Memory wait of 3 cycles overriding a load-use hazard.
    for (int i = 0; i < 3; i++) begin
      v = base(); v.m2re = 1; v.rte = 8; v.rsd = 8; v.req = 1;
      drive(v);
      chk("mw.StallF", StallF, 1);
      chk("mw.StallE", StallE, 1);
      chk("mw.StallM", StallM, 1);
      chk("mw.FlushE", FlushE, 0);
      tick(v);
    end
    v = base(); v.req = 1; v.ack = 1;
    drive(v);
    chk("mw.ack.StallF", StallF, 0);
    chk("mw.ack.StallE", StallE, 0);
    tick(v);
    drive(v);
    chk("mw.zero.StallM", StallM, 0);
    tick(v);

    // Timeout: five stalled cycles, then sticky error and no stalls.
    v = base(); v.req = 1;
    for (int i = 0; i < TO + 1; i++) begin
      drive(v);
      chk("to.StallE", StallE, 1);
      chk("to.MemTimeout", MemTimeout, 0);
      tick(v);
    end
    for (int i = 0; i < 2; i++) begin
      drive(v);
      chk("to.err.MemTimeout", MemTimeout, 1);
      chk("to.err.StallE", StallE, 0);
      tick(v);
    end
    do_reset();
    v = base();
    drive(v);
    chk("to.rst.MemTimeout", MemTimeout, 0);
    chk("to.rst.StallCount", StallCount, 0);
    tick(v);

    // Reset mid-wait: the access restarts with a fresh budget.
    v = base(); v.req = 1;
    for (int i = 0; i < 2; i++) begin
      drive(v); tick(v);
    end
    v.rst = 0;
    drive(v); tick(v);
    v.rst = 1;
    for (int i = 0; i < TO + 1; i++) begin
      drive(v);
      chk("rmw.StallM", StallM, 1);
      tick(v);
    end
    drive(v);
    chk("rmw.MemTimeout", MemTimeout, 1);
    tick(v);
    do_reset();

    // Counter saturation.
    v = base(); v.m2re = 1; v.rte = 2; v.rtd = 2;
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(v); tick(v);
    end
    v = base();
    drive(v);
    chk("sat.StallCount", StallCount, CMAX);
    tick(v);

    for (int n = 0; n < 3000; n++) begin
      v.rsd = 5'($urandom_range(0, 3));
      v.rtd = 5'($urandom_range(0, 3));
      v.rse = 5'($urandom_range(0, 3));
      v.rte = 5'($urandom_range(0, 3));
      v.wre = 5'($urandom_range(0, 3));
      v.wrm = 5'($urandom_range(0, 3));
      v.wrw = 5'($urandom_range(0, 3));
      v.rwe = 1'($urandom_range(0, 1));
      v.rwm = 1'($urandom_range(0, 1));
      v.rww = 1'($urandom_range(0, 1));
      v.m2re = 1'($urandom_range(0, 1));
      v.m2rm = 1'($urandom_range(0, 1));
      v.brd = 1'($urandom_range(0, 1));
      v.req = 1'($urandom_range(0, 1));
      v.ack = ($urandom_range(0, 2) == 0);
      v.rst = ($urandom_range(0, 39) != 0);
      drive(v);
      tick(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
